// File: rtl/ntt_out_serializer.sv
// ntt_out_serializer
//
// Sits after the pipelined radix-2 NTT. Each time the NTT pulses
// data_valid_in, the whole N-coefficient result vector is captured into
// one of two vector slots. The coefficients are then streamed out one per
// cycle over a valid/ready interface. The NTT cannot be stalled, so a
// vector that arrives while both slots are occupied is dropped. That
// event sets the sticky overflow flag.
//
// Optional feature macro: NTT_SER_BITREV_EN
//   defined     -> coefficients leave in bit-reversed index order, and
//                  m_index reports the reversed index
//   not defined -> natural order 0..N-1
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   data_valid_in  in   one-cycle capture pulse from the NTT
//   Data_in[0:N-1] in   coefficient vector, sampled only on data_valid_in
//   m_valid        out  a coefficient is presented
//   m_ready        in   consumer accepts the presented coefficient
//   m_data         out  presented coefficient
//   m_index        out  index of m_data within its vector
//   m_last         out  final beat of the vector
//   busy           out  at least one slot occupied
//   overflow       out  sticky, an incoming vector was dropped
//
// Read FSM states
//   state  | meaning
//   IDLE   | no slot occupied, nothing presented
//   STREAM | slot rd_ptr is being emitted, beat selects the coefficient

module ntt_out_serializer #(
    parameter  int W  = 32,
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_valid_in,
    input  logic [W-1:0]  Data_in [0:N-1],
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    output logic [IW-1:0] m_index,
    output logic          m_last,
    output logic          busy,
    output logic          overflow
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [W-1:0]  mem [0:1][0:N-1];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    occ;
    logic [1:0]    occ_next;
    logic [IW-1:0] beat;
    logic [IW-1:0] sel;

    logic          xfer;
    logic          final_xfer;
    logic          capture;
    logic          drop;

    function automatic logic [IW-1:0] order(input logic [IW-1:0] b);
        logic [IW-1:0] r;
`ifdef NTT_SER_BITREV_EN
        for (int i = 0; i < IW; i++) begin
            r[i] = b[IW-1-i];
        end
`else
        r = b;
`endif
        return r;
    endfunction

    assign sel = order(beat);

    // Transfer qualification depends only on registered state, so there
    // is no path from m_ready into the outputs.
    assign xfer       = (state == STREAM) && m_ready;
    assign final_xfer = xfer && (beat == IW'(N - 1));

    // When both slots are full, a final-beat transfer frees the slot that
    // wr_ptr already points at. The incoming vector can then take that
    // slot on the same edge.
    assign capture = data_valid_in && ((occ != 2'd2) || final_xfer);
    assign drop    = data_valid_in && !capture;

    always_comb begin
        occ_next = occ;
        if (capture && !final_xfer) begin
            occ_next = occ + 2'd1;
        end else if (!capture && final_xfer) begin
            occ_next = occ - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The next state looks at occ_next. This lets a capture into an empty
    // buffer raise m_valid straight after the capture edge. It also lets a
    // buffered second vector follow beat N-1 without a bubble.
    always_comb begin
        state_next = state;
        m_valid    = 1'b0;
        m_data     = '0;
        m_index    = '0;
        m_last     = 1'b0;
        case (state)
            IDLE: begin
                if (occ_next != 2'd0) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                m_valid = 1'b1;
                m_data  = mem[rd_ptr][sel];
                m_index = sel;
                m_last  = (beat == IW'(N - 1));
                if (occ_next == 2'd0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < N; i++) begin
                    mem[s][i] <= '0;
                end
            end
        end else if (capture) begin
            for (int i = 0; i < N; i++) begin
                mem[wr_ptr][i] <= Data_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            beat     <= '0;
            overflow <= 1'b0;
        end else begin
            occ <= occ_next;
            if (capture) begin
                wr_ptr <= ~wr_ptr;
            end
            if (final_xfer) begin
                beat   <= '0;
                rd_ptr <= ~rd_ptr;
            end else if (xfer) begin
                beat <= beat + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign busy = (occ != 2'd0);

endmodule

// File: doc/ntt_out_serializer.md
# ntt_out_serializer

Downstream stage of the pipelined radix-2 NTT block: captures each full N-coefficient result vector when the NTT asserts its output-valid pulse, then streams the coefficients out one per cycle over a valid/ready interface. The NTT has no backpressure, so this block provides a two-slot vector buffer between it and the slower serial consumer (pointwise multiplier / memory writer). Vectors that arrive while the buffer is full are flagged.

## Interface
- `W`, 32: coefficient width in bits.
- `N`, 8: coefficients per vector; power of two, ≥ 2.
- `IW`, `$clog2(N)`: index width (derived; not overridden).

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_valid_in`  in  1  one-cycle pulse from the NTT `data_valid_out`.
- `Data_in[0:N-1]`  in  W each  NTT `Data_out` vector; sampled only when `data_valid_in`=1.
- `m_valid`  out  1  a coefficient is presented.
- `m_ready`  in  1  consumer accepts; a beat transfers when `m_valid && m_ready`.
- `m_data`  out  W  current coefficient.
- `m_index`  out  IW  coefficient index of `m_data` within its vector.
- `m_last`  out  1  high on the final beat of a vector.
- `busy`  out  1  at least one buffer slot occupied.
- `overflow`  out  1  sticky: an incoming vector was dropped.

## Operation
- Storage: two slots of N×W bits, plus `wr_ptr`, `rd_ptr` (1 bit each), `occ` (0..2) and beat counter `beat` (IW bits).
- Capture: on `data_valid_in`=1, if `occ`<2, or `occ`=2 and the final beat of the read slot transfers in the same cycle, the whole vector is written to slot `wr_ptr` and `wr_ptr` toggles. Otherwise the vector is discarded, `overflow`←1, and buffer contents are unchanged.
- Read FSM: IDLE (`occ`=0, `m_valid`=0) → STREAM when `occ`≥1. In STREAM, `m_valid`=1, `m_data`=slot[`rd_ptr`][order(`beat`)], `m_index`=order(`beat`), `m_last`=(`beat`=N-1).
- On transfer: `beat`++. On transfer with `beat`=N-1: `beat`←0, `rd_ptr` toggles, slot freed. If the other slot is occupied, stay in STREAM; otherwise return to IDLE.
- `occ` next = `occ` + capture − final-beat-transfer. Simultaneous capture and free leaves `occ` unchanged.
- While `m_valid`=1 and `m_ready`=0, `m_data`, `m_index` and `m_last` hold stable.
- `overflow` clears only on reset. `busy`=(`occ`≠0).
- Data is passed through unmodified; no modular arithmetic in this block.

## Timing
- Reset (asynchronous assert, synchronous release): `occ`=0, pointers=0, `beat`=0, buffer slots=0, FSM=IDLE. Outputs: `m_valid`=0, `m_data`=0, `m_index`=0, `m_last`=0, `busy`=0, `overflow`=0. A reset mid-stream aborts the vector immediately, and no further beats are emitted.
- Latency: vector captured at edge k; `m_valid`=1 with beat 0 from cycle k+1 (one cycle).
- Throughput: with `m_ready` held at 1, N beats per vector, and consecutive buffered vectors stream with no bubble (beat N-1 of vector A is followed directly by beat 0 of vector B).
- `m_valid` never deasserts mid-vector. It falls only after a final-beat transfer with `occ` becoming 0.
- A capture into an empty buffer in the same cycle as nothing else yields `m_valid` the next cycle. There is no combinational path from `data_valid_in` or `m_ready` to any output.

## Configuration
- `NTT_SER_BITREV_EN` defined: order(b)=bit-reverse of b over IW bits, so coefficients are emitted in bit-reversed index order and `m_index` reports that reversed index. Used when the consumer expects the NTT's natural internal order.
- Not defined: order(b)=b, natural order 0..N-1.

## Test plan
- Vector 1..8 captured, `m_ready`=1 → `m_valid` rises the cycle after capture. Beats carry data 1,2,…,8 with index 0..7. `m_last` only on data 8. `busy` falls after the last beat.
- Same vector, `m_ready` low for 3 cycles while beat 2 (data 3) is presented → `m_data`=3 and `m_index`=2 hold for all 3 cycles, then streaming resumes at 4. Total of 8 transfers, no duplicates.
- Three vectors (A=10..17, B=20..27, C=30..37) pulsed on consecutive cycles with `m_ready`=0 → C dropped, `overflow`=1. With `m_ready` then 1: 16 beats A then B with no bubble, and `overflow` stays 1.
- Buffer full, and a new vector D (40..47) arrives in the same cycle as A's final beat transfers → D captured, `overflow` stays 0. Output order: B, then D.
- Assert `reset` low at beat 4 of a stream → all outputs 0 immediately. After release, no beats until the next `data_valid_in`.
- `NTT_SER_BITREV_EN` defined, vector 0..7 → emitted data 0,4,2,6,1,5,3,7, with `m_index` equal to the data value.
